// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and an optional 2-entry skid buffer.
// Control bits read as zero whenever the stage holds no entry.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  // With the skid buffer, ready is a flop so back-pressure never ripples upstream combinationally.
  assign in_ready  = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d     = ST_ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire) begin
          if (SKID != 0) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end else if (out_fire) begin
          state_d     = ST_EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        main_data_d = '0;
        main_ctrl_d = '0;
        skid_data_d = '0;
        skid_ctrl_d = '0;
      end
    endcase
    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid (SKID=1 and SKID=0 instances)
// against a queue-based FIFO reference model.
module tb_pipe_stage_skid;
  localparam int DW = 69;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush;
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]    a_occ;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [1:0]    b_occ;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t ma[$];
  ent_t mb[$];
  bit   model_on = 1'b0;
  bit   a_acc = 1'b0, b_acc = 1'b0;
  bit   a_stall = 1'b0, b_stall = 1'b0;
  logic [DW-1:0] a_prev_d, b_prev_d;
  logic [CW-1:0] a_prev_c, b_prev_c;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Reference model: a FIFO of entries, capacity 2 (SKID=1) or ready-follows-downstream (SKID=0).
  always @(posedge clk) begin
    if (a_stall && a_in_valid)
      assert (a_in_data == a_prev_d && a_in_ctrl == a_prev_c)
        else $error("upstream payload changed while stalled (a)");
    if (b_stall && b_in_valid)
      assert (b_in_data == b_prev_d && b_in_ctrl == b_prev_c)
        else $error("upstream payload changed while stalled (b)");
    a_stall  <= a_in_valid & ~a_in_ready;
    b_stall  <= b_in_valid & ~b_in_ready;
    a_prev_d <= a_in_data;
    a_prev_c <= a_in_ctrl;
    b_prev_d <= b_in_data;
    b_prev_c <= b_in_ctrl;
    a_acc    <= a_in_valid & a_in_ready;
    b_acc    <= b_in_valid & b_in_ready;

    if (reset) begin
      ma.delete();
      mb.delete();
      model_on <= 1'b1;
    end else if (flush) begin
      ma.delete();
      mb.delete();
    end else begin
      if (a_in_valid && ma.size() != 2) begin
        if (ma.size() != 0 && a_out_ready) void'(ma.pop_front());
        ma.push_back({a_in_data, a_in_ctrl});
      end else if (ma.size() != 0 && a_out_ready) begin
        void'(ma.pop_front());
      end
      if (b_in_valid && (b_out_ready || mb.size() == 0)) begin
        if (mb.size() != 0 && b_out_ready) void'(mb.pop_front());
        mb.push_back({b_in_data, b_in_ctrl});
      end else if (mb.size() != 0 && b_out_ready) begin
        void'(mb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    ent_t ha, hb;
    #1;
    if (model_on) begin
      ha = (ma.size() != 0) ? ma[0] : '0;
      hb = (mb.size() != 0) ? mb[0] : '0;
      chk("a.out_valid", a_out_valid, ma.size() != 0);
      chk("a.out_data",  a_out_data,  ha.d);
      chk("a.out_ctrl",  a_out_ctrl,  ha.c);
      chk("a.occupancy", a_occ,       128'(ma.size()));
      chk("a.in_ready",  a_in_ready,  ma.size() != 2);
      chk("b.out_valid", b_out_valid, mb.size() != 0);
      chk("b.out_data",  b_out_data,  hb.d);
      chk("b.out_ctrl",  b_out_ctrl,  hb.c);
      chk("b.occupancy", b_occ,       128'(mb.size()));
      chk("b.in_ready",  b_in_ready,  b_out_ready || mb.size() == 0);
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    step();
    reset = 1'b0;
    chk("reset.out_valid", a_out_valid, 1'b0);
    chk("reset.out_data",  a_out_data,  '0);
    chk("reset.occupancy", a_occ,       2'd0);
    chk("reset.in_ready",  a_in_ready,  1'b1);

    // Streaming: one entry per cycle, one cycle of latency.
    a_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1'b1; a_in_data = DW'(i); a_in_ctrl = CW'(i);
      step();
      chk("stream.out_data",  a_out_data, 128'(i));
      chk("stream.occupancy", a_occ,      2'd1);
      chk("stream.in_ready",  a_in_ready, 1'b1);
    end
    a_in_valid = 1'b0;
    step();
    chk("stream.drain", a_occ, 2'd0);

    // Back-pressure.
    a_in_valid = 1'b1; a_in_data = DW'(10);
    step();
    chk("bp.first", a_out_data, 128'd10);
    a_out_ready = 1'b0; a_in_data = DW'(11);
    step();
    chk("bp.occ2", a_occ, 2'd2);
    chk("bp.ready_low", a_in_ready, 1'b0);
    a_in_data = DW'(12);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp.hold_data", a_out_data, 128'd10);
      chk("bp.hold_occ",  a_occ,      2'd2);
    end
    a_out_ready = 1'b1;
    step();
    chk("bp.emit11", a_out_data, 128'd11);
    step();
    chk("bp.emit12", a_out_data, 128'd12);
    a_in_valid = 1'b0;
    step();
    chk("bp.empty", a_occ, 2'd0);

    // Flush while full.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = DW'(20); a_in_ctrl = 4'hF;
    step();
    a_in_data = DW'(21);
    step();
    chk("flush.pre_occ", a_occ, 2'd2);
    a_in_data = DW'(22); flush = 1'b1;
    step();
    flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk("flush.out_valid", a_out_valid, 1'b0);
    chk("flush.out_ctrl",  a_out_ctrl,  '0);
    chk("flush.occupancy", a_occ,       2'd0);
    chk("flush.in_ready",  a_in_ready,  1'b1);
    step();
    chk("flush.stays_empty", a_out_valid, 1'b0);

    // Bubble control masking.
    a_in_valid = 1'b0; a_in_ctrl = '1;
    for (int i = 0; i < 3; i++) begin
      a_out_ready = 1'($urandom_range(0, 1));
      step();
      chk("bubble.out_valid", a_out_valid, 1'b0);
      chk("bubble.out_ctrl",  a_out_ctrl,  '0);
    end

    // Synchronous reset mid-operation.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = DW'(30); a_in_ctrl = 4'h3;
    step();
    a_in_data = DW'(31);
    step();
    a_in_valid = 1'b0; a_out_ready = 1'b1; reset = 1'b1;
    #1;
    chk("rst.before_edge_occ",  a_occ,      2'd2);
    chk("rst.before_edge_data", a_out_data, 128'd30);
    step();
    reset = 1'b0;
    chk("rst.out_valid", a_out_valid, 1'b0);
    chk("rst.out_data",  a_out_data,  '0);
    chk("rst.occupancy", a_occ,       2'd0);
    chk("rst.in_ready",  a_in_ready,  1'b1);

    // SKID=0: combinational ready.
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = DW'(5); b_in_ctrl = 4'h1;
    step();
    chk("skid0.held", b_out_valid, 1'b1);
    b_in_data = DW'(6);
    #1;
    chk("skid0.ready_low", b_in_ready, 1'b0);
    b_out_ready = 1'b1; b_in_data = DW'(7);
    #1;
    chk("skid0.ready_high", b_in_ready, 1'b1);
    step();
    chk("skid0.data7", b_out_data, 128'd7);
    chk("skid0.occ1",  b_occ,      2'd1);
    b_in_valid = 1'b0;
    step();
    chk("skid0.empty", b_occ, 2'd0);

    // Randomised traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      if (!(a_in_valid && !a_acc)) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_in_data  = DW'({$urandom(), $urandom(), $urandom()});
        a_in_ctrl  = CW'($urandom());
      end
      if (!(b_in_valid && !b_acc)) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_in_data  = DW'({$urandom(), $urandom(), $urandom()});
        b_in_ctrl  = CW'($urandom());
      end
      a_out_ready = ($urandom_range(0, 9) < ((i < 1500) ? 7 : 3));
      b_out_ready = ($urandom_range(0, 9) < ((i < 1500) ? 7 : 3));
      flush = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    flush = 1'b0; reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
